uart_main: RTL and testbench
============================

# uart_main

Loopback-capable UART block that serialises one W_OUT-bit parallel word as NUM_WORDS back-to-back 8N1 characters on `tx`, and deserialises NUM_WORDS characters from `rx` into one W_OUT-bit word. It sits between a parallel valid/ready stream interface and a board-level serial pin pair. The TX and RX paths are independent and may run concurrently.

## Interface
- `CLOCKS_PER_PULSE`, default 16: clock cycles per serial bit; integer ≥ 4.
- `W_OUT`, default 16: parallel word width; a multiple of `BITS_PER_WORD`.
- `BITS_PER_WORD`, default 8: data bits per serial character.
- `NUM_WORDS` (derived localparam) = `W_OUT / BITS_PER_WORD`.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rstn`  in  1  synchronous reset; despite its name it is active-high, so 1 resets.
- `rx`  in  1  serial input, idle high; asynchronous to `clk`.
- `s_valid`  in  1  TX request.
- `s_data`  in  [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  TX payload, packed; word 0 = bits [BITS_PER_WORD-1:0].
- `tx`  out  1  serial output, idle high.
- `tx_ready`  out  1  TX idle; able to accept a request.
- `m_valid`  out  1  one-cycle pulse when a full RX word is ready.
- `m_data`  out  W_OUT  last received word.

## Operation
- **Reset values:** `tx`=1, `tx_ready`=1, `m_valid`=0, `m_data`=0; both FSMs return to IDLE and all counters clear. Reset asserted mid-frame aborts the frame immediately.
- **Character format (8N1):**
  - 1 start bit (0).
  - `BITS_PER_WORD` data bits, LSB first.
  - 1 stop bit (1).
  - Each bit lasts exactly `CLOCKS_PER_PULSE` cycles.
- **TX FSM (IDLE → START → DATA → STOP):**
  - In IDLE, a request is accepted on a cycle with `s_valid`=1 and `tx_ready`=1.
  - On acceptance, `s_data` is latched and `tx_ready` drops the next cycle.
  - A `s_valid` held high for several cycles therefore causes exactly one transfer.
  - Words are sent in order 0..NUM_WORDS-1. Word k+1's start bit follows word k's stop bit with no idle gap.
  - After the last stop bit completes, the FSM returns to IDLE and `tx_ready`=1.
  - `s_data` changes after acceptance have no effect.
- **RX FSM (IDLE → START → DATA → STOP):**
  - `rx` passes through a 2-flop synchroniser first.
  - In IDLE, a synchronised low level enters START.
  - At `CLOCKS_PER_PULSE/2` cycles, the line is re-checked. If it is high, the start is a glitch and the FSM returns to IDLE.
  - Each data bit is then sampled every `CLOCKS_PER_PULSE` cycles, at mid-bit, and shifted in LSB first.
  - At the stop-bit sample:
    - If the line is 1, the character is stored into word slot k (first received character goes to `m_data[BITS_PER_WORD-1:0]`) and k increments.
    - If the line is 0 (framing error), the character and any partial packet are discarded, k resets to 0, and the FSM waits for the line to return high before re-arming IDLE.
  - When k reaches NUM_WORDS, the assembled word is copied to `m_data`, `m_valid` pulses for exactly one cycle, and k resets to 0.
  - `m_data` holds its value until the next complete packet.
  - RX must accept back-to-back characters: a new start may be detected from the stop-bit mid-sample onward.

## Timing
- TX: `tx` falls (start bit) on the cycle after acceptance. The packet occupies `NUM_WORDS*(BITS_PER_WORD+2)*CLOCKS_PER_PULSE` cycles, which is 320 for the defaults.
- `tx_ready` rises the cycle after the final stop bit ends.
- RX: `m_valid` asserts within `CLOCKS_PER_PULSE/2 + 3` cycles after the start of the last stop bit.
- Loopback latency from `s_valid` acceptance to `m_valid` for the defaults is ≤ 320 cycles.
- No back-pressure on the RX side. A new packet overwrites `m_data`.

## Structure
- Package `uart_pkg` holds:
  - the TX and RX state enums (IDLE, START, DATA, STOP);
  - a helper function for the bit-counter width, `$clog2`.
- Leaf modules:
  - `uart_tx`: character serialiser with a word counter.
  - `uart_rx`: synchroniser, mid-bit sampler and word assembler.
- `uart_main` only instantiates these two and wires the packing/unpacking.

## Test plan
- **Reset:** hold `rstn`=1 for 2 cycles with `rx`=1 → `tx`=1, `tx_ready`=1, `m_valid`=0, `m_data`=0.
- **Loopback:** `tx` wired to `rx`; send `s_data`=16'hA53C with `s_valid` held 3 cycles →
  - exactly one packet; `tx` shows 0,0011_1100,1 then 0,1010_0101,1 (LSB first on the wire);
  - `m_valid` pulses once; `m_data`=16'hA53C.
- **Back-to-back:** send 16'h00FF, then 16'hFFFF once `tx_ready` returns → `m_data` equals each value in turn; two `m_valid` pulses.
- **Busy reject:** pulse `s_valid` with 16'h1234 while `tx_ready`=0 → ignored; no extra packet on `tx`.
- **Framing error:** drive `rx` with 8'h55 and stop bit 0, then a valid 2-character packet 8'h11, 8'h22 → no `m_valid` for the bad frame; then `m_valid` with `m_data`=16'h2211.
- **Glitch and mid-frame reset:**
  - A 3-cycle low pulse on idle `rx` → no reception.
  - Reset asserted halfway through a TX packet → `tx`=1 and `tx_ready`=1 the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART slice: TX/RX state encodings and counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // RX_WAIT holds off re-arming after a framing error until the line idles high.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser: synchroniser, mid-bit sampler and multi-character word assembler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CPP = 16,
  parameter int BPW = 8,
  parameter int NW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              valid_o,
  output logic [NW*BPW-1:0] data_o,
  output rx_state_e         state_o
);

  localparam int CW = cnt_width(CPP);
  localparam int BW = cnt_width(BPW);
  localparam int WW = cnt_width(NW);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CPP - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPP / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BPW - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NW - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [BPW-1:0]    shreg_q, shreg_d;
  logic [NW*BPW-1:0] buf_q, buf_d;
  logic [NW*BPW-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 2'b11;
      state_q    <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_i};
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d   = RX_START;
          clk_cnt_d = '0;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start, high means a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s, shreg_q[BPW-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            for (int i = 0; i < NW; i++) begin
              if (word_cnt_q == WW'(i)) buf_d[i*BPW +: BPW] = shreg_q;
            end
            if (word_cnt_q == WORD_LAST) begin
              data_d     = buf_d;
              valid_d    = 1'b1;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            state_d = RX_IDLE;
          end else begin
            word_cnt_d = '0;
            buf_d      = '0;
            state_d    = RX_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign state_o = state_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: latches a multi-character word and sends it as back-to-back characters.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CPP = 16,
  parameter int BPW = 8,
  parameter int NW  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [NW*BPW-1:0] data_i,
  output logic              tx_o,
  output logic              ready_o,
  output tx_state_e         state_o
);

  localparam int CW = cnt_width(CPP);
  localparam int BW = cnt_width(BPW);
  localparam int WW = cnt_width(NW);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CPP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BPW - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NW - 1);

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [NW*BPW-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= TX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    case (state_q)
      TX_IDLE: begin
        if (valid_i) begin
          state_d    = TX_START;
          shreg_d    = data_i;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      TX_START: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          state_d   = TX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          // The whole word shifts, so the next character lands in the low bits.
          clk_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = TX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (word_cnt_q == WORD_LAST) begin
            state_d = TX_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = TX_START;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o    = tx_q;
  assign ready_o = (state_q == TX_IDLE);
  assign state_o = state_q;

endmodule

// File: rtl/uart_main.sv
// UART top: parallel word in/out over NUM_WORDS back-to-back 8N1 characters.
module uart_main
  import uart_pkg::*;
#(
  parameter  int CLOCKS_PER_PULSE = 16,
  parameter  int W_OUT            = 16,
  parameter  int BITS_PER_WORD    = 8,
  localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    rx,
  input  logic                                    s_valid,
  input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] s_data,
  output logic                                    tx,
  output logic                                    tx_ready,
  output logic                                    m_valid,
  output logic [W_OUT-1:0]                        m_data,
  output tx_state_e                               tx_state_dbg,
  output rx_state_e                               rx_state_dbg
);

  // Handshake: a TX transfer happens on the cycle s_valid && tx_ready; s_data is
  // captured then and ignored afterwards. RX has no ready: m_valid is a single-cycle
  // pulse and m_data holds the word until the next packet completes.
  uart_tx #(
    .CPP (CLOCKS_PER_PULSE),
    .BPW (BITS_PER_WORD),
    .NW  (NUM_WORDS)
  ) u_tx (
    .clk_i   (clk),
    .rst_i   (rstn),
    .valid_i (s_valid),
    .data_i  (s_data),
    .tx_o    (tx),
    .ready_o (tx_ready),
    .state_o (tx_state_dbg)
  );

  uart_rx #(
    .CPP (CLOCKS_PER_PULSE),
    .BPW (BITS_PER_WORD),
    .NW  (NUM_WORDS)
  ) u_rx (
    .clk_i   (clk),
    .rst_i   (rstn),
    .rx_i    (rx),
    .valid_o (m_valid),
    .data_o  (m_data),
    .state_o (rx_state_dbg)
  );

endmodule

// File: tb/tb_uart_main.sv
// Directed bench for uart_main: loopback, back-to-back, busy reject, framing, glitch, reset.
module tb_uart_main;
  import uart_pkg::*;

  localparam int CPP = 16;
  localparam int W   = 16;
  localparam int BPW = 8;
  localparam int NW  = W / BPW;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b1;
  logic                   rx_drv = 1'b1;
  logic                   loop_en = 1'b0;
  logic                   s_valid = 1'b0;
  logic [NW-1:0][BPW-1:0] s_data = '0;
  logic                   rx;
  logic                   tx, tx_ready, m_valid;
  logic [W-1:0]           m_data;
  tx_state_e              tx_state_dbg;
  rx_state_e              rx_state_dbg;

  int checks = 0;
  int errors = 0;
  int mv_count = 0;
  logic [W-1:0] exp_q[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_main #(
    .CLOCKS_PER_PULSE (CPP),
    .W_OUT            (W),
    .BITS_PER_WORD    (BPW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx           (rx),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .tx           (tx),
    .tx_ready     (tx_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every m_valid pulse pops one expected word.
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      mv_count++;
      if (exp_q.size() == 0) check("m_valid_unexpected", 32'(exp_q.size()), 1);
      else check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks; all are entered 1 time unit after a rising edge.
  task automatic wait_ready(input int budget);
    int n = 0;
    while (tx_ready !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 1);
  endtask

  task automatic send_and_check(input logic [W-1:0] data, input int hold);
    logic [BPW+1:0] frame;
    check("tx_ready_pre", 32'(tx_ready), 1);
    s_valid = 1'b1;
    s_data  = data;
    exp_q.push_back(data);
    @(posedge clk); #1;
    check("tx_ready_drop", 32'(tx_ready), 0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (CPP/2 - hold + 1) @(posedge clk);
    #1;
    for (int w = 0; w < NW; w++) begin
      frame = {1'b1, data[w*BPW +: BPW], 1'b0};
      for (int b = 0; b < BPW + 2; b++) begin
        check($sformatf("tx_w%0d_b%0d", w, b), 32'(tx), 32'(frame[b]));
        repeat (CPP) @(posedge clk);
        #1;
      end
    end
    check("tx_ready_after_pkt", 32'(tx_ready), 1);
    check("tx_idle_after_pkt", 32'(tx), 1);
  endtask

  task automatic start_tx(input logic [W-1:0] data, input bit push);
    s_valid = 1'b1;
    s_data  = data;
    if (push) exp_q.push_back(data);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drive_char(input logic [BPW-1:0] ch, input logic stop);
    logic [BPW+1:0] frame;
    frame = {stop, ch, 1'b0};
    for (int b = 0; b < BPW + 2; b++) begin
      rx_drv = frame[b];
      repeat (CPP) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  int mv0;
  int tx_low;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    rstn = 1'b0;
    @(posedge clk); #1;

    // Loopback, s_valid held 3 cycles -> one packet
    loop_en = 1'b1;
    mv0 = mv_count;
    send_and_check(16'hA53C, 3);
    repeat (2*CPP) @(posedge clk);
    #1;
    check("loop_tx_still_idle", 32'(tx), 1);
    check("loop_mvalid_count", mv_count - mv0, 1);

    // Back-to-back
    mv0 = mv_count;
    send_and_check(16'h00FF, 1);
    wait_ready(400);
    send_and_check(16'hFFFF, 1);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_mvalid_count", mv_count - mv0, 2);

    // Busy reject
    mv0 = mv_count;
    start_tx(16'h5A5A, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("busy_ready_low", 32'(tx_ready), 0);
    s_valid = 1'b1;
    s_data  = 16'h1234;
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_ready(400);
    tx_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) tx_low++;
    end
    check("busy_no_extra_pkt", tx_low, 0);
    check("busy_mvalid_count", mv_count - mv0, 1);

    // Framing error followed by a good packet
    loop_en = 1'b0;
    mv0 = mv_count;
    drive_char(8'h55, 1'b0);
    repeat (2*CPP) @(posedge clk);
    #1;
    check("frame_err_no_mvalid", mv_count - mv0, 0);
    exp_q.push_back(16'h2211);
    drive_char(8'h11, 1'b1);
    drive_char(8'h22, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("frame_good_mvalid", mv_count - mv0, 1);

    // Glitch on idle rx, then a good packet
    mv0 = mv_count;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (2*CPP) @(posedge clk);
    #1;
    check("glitch_rx_idle", 32'(rx_state_dbg), 32'(RX_IDLE));
    check("glitch_no_mvalid", mv_count - mv0, 0);
    exp_q.push_back(16'h4433);
    drive_char(8'h33, 1'b1);
    drive_char(8'h44, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("glitch_good_mvalid", mv_count - mv0, 1);

    // Reset halfway through a TX packet
    loop_en = 1'b1;
    mv0 = mv_count;
    start_tx(16'hBEEF, 1'b0);
    repeat (160) @(posedge clk);
    #1;
    check("mid_busy", 32'(tx_ready), 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_tx_ready", 32'(tx_ready), 1);
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_m_data", 32'(m_data), 0);
    rstn = 1'b0;
    tx_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) tx_low++;
    end
    check("mid_rst_tx_quiet", tx_low, 0);
    check("mid_rst_no_mvalid", mv_count - mv0, 0);

    // Final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
